// File: rtl/mc_port_arbiter.sv
// mc_port_arbiter: shares one Convey MC port among NUM_REQ requesters.
// Round-robin request arbitration into a one-entry registered stage, response
// routing by the requester ID carried in rtnctl, and MC write-flush sequencing.
module mc_port_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_W         = 2,
    parameter int unsigned RTNCTL_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   i_reset_n,
    input  logic [NUM_REQ-1:0]                     rq_vld,
    output logic [NUM_REQ-1:0]                     rq_rdy,
    input  logic [NUM_REQ*(RTNCTL_WIDTH-ID_W)-1:0] rq_rtnctl,
    input  logic [NUM_REQ*64-1:0]                  rq_data,
    input  logic [NUM_REQ*48-1:0]                  rq_vadr,
    input  logic [NUM_REQ*2-1:0]                   rq_size,
    input  logic [NUM_REQ*3-1:0]                   rq_cmd,
    input  logic [NUM_REQ*4-1:0]                   rq_scmd,
    input  logic [NUM_REQ-1:0]                     flush_req,
    output logic [NUM_REQ-1:0]                     flush_done,
    output logic [NUM_REQ-1:0]                     rs_vld,
    input  logic [NUM_REQ-1:0]                     rs_rdy,
    output logic [2:0]                             rs_cmd,
    output logic [3:0]                             rs_scmd,
    output logic [63:0]                            rs_data,
    output logic [RTNCTL_WIDTH-ID_W-1:0]           rs_rtnctl,
    output logic                                   mc_rq_vld,
    output logic [RTNCTL_WIDTH-1:0]                mc_rq_rtnctl,
    output logic [63:0]                            mc_rq_data,
    output logic [47:0]                            mc_rq_vadr,
    output logic [1:0]                             mc_rq_size,
    output logic [2:0]                             mc_rq_cmd,
    output logic [3:0]                             mc_rq_scmd,
    input  logic                                   mc_rq_stall,
    input  logic                                   mc_rs_vld,
    input  logic [2:0]                             mc_rs_cmd,
    input  logic [3:0]                             mc_rs_scmd,
    input  logic [63:0]                            mc_rs_data,
    input  logic [RTNCTL_WIDTH-1:0]                mc_rs_rtnctl,
    output logic                                   mc_rs_stall,
    output logic                                   mc_rq_flush,
    input  logic                                   mc_rs_flush_cmplt
);

    localparam int unsigned UW = RTNCTL_WIDTH - ID_W;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [NUM_REQ-1:0] flush_mask;
    logic               full;
    logic [ID_W-1:0]    last;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_found;
    logic               grant;
    logic               transfer;
    logic               slot_free;
    logic [ID_W-1:0]    rs_id;

    assign transfer  = full & ~mc_rq_stall;
    assign slot_free = ~full | ~mc_rq_stall;

    // Round-robin search: first valid requester after the last winner, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last) + k) % NUM_REQ);
            if (!grant_found && rq_vld[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Grants only when the stage can accept and no flush is pending or running.
    assign grant  = grant_found & slot_free & (state == ST_IDLE) & ~(|flush_req) & i_reset_n;
    assign rq_rdy = grant ? (NUM_REQ'(1) << grant_idx) : '0;

    // Output stage: load on grant, empty on transfer, hold while stalled.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            full         <= 1'b0;
            last         <= LAST_RST;
            mc_rq_rtnctl <= '0;
            mc_rq_data   <= '0;
            mc_rq_vadr   <= '0;
            mc_rq_size   <= '0;
            mc_rq_cmd    <= '0;
            mc_rq_scmd   <= '0;
        end else if (grant) begin
            full         <= 1'b1;
            last         <= grant_idx;
            mc_rq_rtnctl <= {grant_idx, rq_rtnctl[32'(grant_idx)*UW +: UW]};
            mc_rq_data   <= rq_data[32'(grant_idx)*64 +: 64];
            mc_rq_vadr   <= rq_vadr[32'(grant_idx)*48 +: 48];
            mc_rq_size   <= rq_size[32'(grant_idx)*2 +: 2];
            mc_rq_cmd    <= rq_cmd[32'(grant_idx)*3 +: 3];
            mc_rq_scmd   <= rq_scmd[32'(grant_idx)*4 +: 4];
        end else if (transfer) begin
            full         <= 1'b0;
        end
    end

    assign mc_rq_vld = full;

    // Flush state register.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush next-state: drain the stage, pulse the flush, wait for completion.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (|flush_req) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!full || transfer) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (mc_rs_flush_cmplt) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Flush mask capture and registered flush outputs.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            flush_mask  <= '0;
            mc_rq_flush <= 1'b0;
            flush_done  <= '0;
        end else begin
            if (state == ST_IDLE && |flush_req) begin
                flush_mask <= flush_req;
            end
            mc_rq_flush <= (state_nxt == ST_ISSUE);
            flush_done  <= (state_nxt == ST_DONE) ? flush_mask : '0;
        end
    end

    // Response routing; IDs beyond NUM_REQ are dropped.
    assign rs_id     = mc_rs_rtnctl[RTNCTL_WIDTH-1 -: ID_W];
    assign rs_vld    = (mc_rs_vld && i_reset_n && (32'(rs_id) < NUM_REQ)) ?
                       (NUM_REQ'(1) << rs_id) : '0;
    assign rs_cmd    = mc_rs_cmd;
    assign rs_scmd   = mc_rs_scmd;
    assign rs_data   = mc_rs_data;
    assign rs_rtnctl = mc_rs_rtnctl[UW-1:0];

    // Almost-full style response backpressure, one cycle behind rs_rdy.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mc_rs_stall <= 1'b0;
        end else begin
            mc_rs_stall <= |(~rs_rdy);
        end
    end

endmodule
